// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract/accumulate unit with valid/ready handshake
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   in_valid  in   op/A/B valid
//   in_ready  out  transaction accepted this cycle (= pipeline advance)
//   op        in   00 add, 01 subtract, 10 accumulate, 11 clear accumulator
//   A, B      in   WIDTH-bit operands (B unused by op 10/11)
//   out_valid out  sum/ovf hold a result
//   out_ready in   consumer takes the result this cycle
//   sum       out  WIDTH+1-bit result
//   ovf       out  signed overflow (add/sub) or accumulator carry-out
module adder_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);
  logic               adv, acc_en, ovf_d;
  logic [WIDTH:0]     add_d, sub_d, res_d, acc_q, acc_d;
  logic [WIDTH+1:0]   accum_d;
  logic [LATENCY-1:0] vld_q, ovf_q;
  logic [WIDTH:0]     sum_q [LATENCY];
  // the whole pipeline moves in lockstep; bubbles are kept, not squeezed out
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign acc_en    = in_valid & adv;
  assign out_valid = vld_q[LATENCY-1];
  assign sum       = sum_q[LATENCY-1];
  assign ovf       = ovf_q[LATENCY-1];
  // results are computed at acceptance so the accumulator sees ops in order
  always_comb begin
    add_d   = {1'b0, A} + {1'b0, B};
    sub_d   = {1'b0, A} - {1'b0, B};
    accum_d = {1'b0, acc_q} + {2'b0, A};
    res_d   = op == 2'd0 ? add_d : op == 2'd1 ? sub_d : op == 2'd2 ? accum_d[WIDTH:0] : '0;
    ovf_d   = op == 2'd0 ? (A[WIDTH-1] == B[WIDTH-1]) && (add_d[WIDTH-1] != A[WIDTH-1]) :
              op == 2'd1 ? (A[WIDTH-1] != B[WIDTH-1]) && (sub_d[WIDTH-1] != A[WIDTH-1]) :
              op == 2'd2 ? accum_d[WIDTH+1] : 1'b0;
    acc_d   = !acc_en ? acc_q : op == 2'd2 ? accum_d[WIDTH:0] : op == 2'd3 ? '0 : acc_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc_q <= '0;
      vld_q <= '0;
      ovf_q <= '0;
      for (int i = 0; i < LATENCY; i++) sum_q[i] <= '0;
    end else begin
      acc_q <= acc_d;
      if (adv) begin
        vld_q[0] <= in_valid;
        sum_q[0] <= res_d;
        ovf_q[0] <= ovf_d;
        for (int i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          sum_q[i] <= sum_q[i-1];
          ovf_q[i] <= ovf_q[i-1];
        end
      end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed and randomized checks of adder_pipe against a behavioural model
module tb_adder_pipe;
  typedef struct packed {
    logic [16:0] s;
    logic        o;
    int          age;
  } ent_t;
  logic clk, rst_n;
  bit   done, fin;
  int   tests = 0, fails = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic ent_t model(int w, logic [1:0] o, longint a, longint b, longint acc);
    longint m, h, sa, sb, r, s;
    bit ov;
    m  = longint'(1) << (w + 1);
    h  = longint'(1) << (w - 1);
    sa = a >= h ? a - 2 * h : a;
    sb = b >= h ? b - 2 * h : b;
    case (o)
      2'd0: begin s = a + b; r = sa + sb; ov = r < -h || r >= h; end
      2'd1: begin s = (a - b + m) % m; r = sa - sb; ov = r < -h || r >= h; end
      2'd2: begin s = (acc + a) % m; ov = acc + a >= m; end
      default: begin s = 0; ov = 0; end
    endcase
    model.s   = 17'(s);
    model.o   = ov;
    model.age = 0;
  endfunction
  for (genvar k = 0; k < 3; k++) begin : g
    localparam int W = k == 0 ? 8 : 16;
    localparam int L = k == 0 ? 2 : k == 1 ? 1 : 4;
    logic         iv, ir, ore, ov, of;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic [W:0]   sm;
    ent_t q[$];
    longint macc;
    adder_pipe #(.WIDTH(W), .LATENCY(L)) dut (
      .clk(clk), .reset(rst_n), .in_valid(iv), .in_ready(ir), .op(op), .A(a), .B(b),
      .out_valid(ov), .out_ready(ore), .sum(sm), .ovf(of)
    );
    initial begin
      bit   ev, adv;
      ent_t e;
      macc = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          q.delete();
          macc = 0;
          tests++;
          if (ov !== 1'b0 || sm !== '0 || of !== 1'b0 || ir !== 1'b1) begin
            fails++;
            $display("FAIL k%0d reset: out_valid=%b sum=%0h ovf=%b in_ready=%b, want 0 0 0 1", k, ov, sm, of, ir);
          end
        end else begin
          ev = q.size() > 0 && q[0].age == L - 1;
          tests++;
          if (ov !== ev || ir !== (ore | !ev)) begin
            fails++;
            $display("FAIL k%0d handshake: out_valid=%b want %b, in_ready=%b want %b", k, ov, ev, ir, ore | !ev);
          end
          if (ev) begin
            tests++;
            if (sm !== q[0].s[W:0] || of !== q[0].o) begin
              fails++;
              $display("FAIL k%0d result: sum=%0h ovf=%b, want sum=%0h ovf=%b", k, sm, of, q[0].s[W:0], q[0].o);
            end
          end
          adv = ore || !ev;
          if (ev && ore) void'(q.pop_front());
          if (adv)
            for (int i = 0; i < q.size(); i++) if (q[i].age < L - 1) q[i].age++;
          if (iv && adv) begin
            e = model(W, op, longint'(a), longint'(b), macc);
            if (op == 2'd2) macc = longint'(e.s);
            if (op == 2'd3) macc = 0;
            q.push_back(e);
          end
        end
      end
    end
    task automatic drive_rand();
      bit hold;
      @(negedge clk);
      hold = iv && !ir;
      @(posedge clk);
      #1;
      if (!hold) begin
        iv = $urandom_range(0, 3) != 0;
        op = 2'($urandom);
        a  = W'($urandom);
        b  = W'($urandom);
      end
      ore = $urandom_range(0, 3) != 0;
    endtask
    if (k == 0) begin : d
      task automatic dchk(input string nm, input longint act, input longint req);
        tests++;
        if (act !== req) begin
          fails++;
          $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
      endtask
      task automatic xact(input logic [1:0] o, input logic [7:0] xa, input logic [7:0] xb,
                          input logic [8:0] es, input logic eo);
        iv = 1; op = o; a = xa; b = xb; ore = 1;
        @(posedge clk);
        #1 iv = 0;
        @(posedge clk);
        @(negedge clk);
        dchk("xact_valid", longint'(ov), 1);
        dchk("xact_sum", longint'(sm), longint'(es));
        dchk("xact_ovf", longint'(of), longint'(eo));
        @(posedge clk);
        #1;
      endtask
      initial begin
        ent_t e;
        logic [8:0] got[$];
        int i, cyc;
        rst_n = 0; iv = 0; op = 0; a = 0; b = 0; ore = 1;
        e = model(8, 2'd0, 200, 100, 0);
        dchk("model_add", longint'(e.s), 300);
        e = model(8, 2'd0, 100, 100, 0);
        dchk("model_add_ovf", longint'(e.o), 1);
        e = model(8, 2'd1, 5, 10, 0);
        dchk("model_sub", longint'(e.s), 507);
        e = model(8, 2'd2, 3, 0, 510);
        dchk("model_acc_wrap", longint'(e.s), 1);
        dchk("model_acc_carry", longint'(e.o), 1);
        repeat (3) @(posedge clk);
        #1;
        dchk("reset_in_ready", longint'(ir), 1);
        dchk("reset_out_valid", longint'(ov), 0);
        rst_n = 1;
        xact(2'd0, 200, 100, 9'h12C, 0);
        xact(2'd0, 100, 100, 9'd200, 1);
        xact(2'd1, 5, 10, 9'h1FB, 0);
        xact(2'd1, 8'h80, 8'h01, 9'h07F, 1);
        xact(2'd3, 0, 0, 9'd0, 0);
        xact(2'd2, 255, 0, 9'd255, 0);
        xact(2'd2, 255, 0, 9'd510, 0);
        xact(2'd2, 3, 0, 9'd1, 1);
        i = 0;
        cyc = 0;
        while (got.size() < 8 && cyc < 100) begin
          ore = !(cyc >= 3 && cyc < 6);
          iv = i < 8; op = 2'd0; a = 8'(i * 10 + 1); b = 8'(i * 3);
          @(negedge clk);
          if (cyc >= 3 && cyc < 6) dchk("stall_in_ready", longint'(ir), 0);
          if (ov && ore) got.push_back(sm);
          if (iv && ir) i++;
          cyc++;
          @(posedge clk);
          #1;
        end
        iv = 0;
        dchk("stream_count", longint'(got.size()), 8);
        for (int j = 0; j < got.size() && j < 8; j++) dchk("stream_sum", longint'(got[j]), longint'(j * 13 + 1));
        iv = 1; op = 2'd2; a = 5; ore = 1;
        @(posedge clk);
        #1 a = 6;
        @(posedge clk);
        #1 iv = 0;
        dchk("inflight_valid", longint'(ov), 1);
        rst_n = 0;
        #1;
        dchk("midreset_out_valid", longint'(ov), 0);
        dchk("midreset_sum", longint'(sm), 0);
        dchk("midreset_in_ready", longint'(ir), 1);
        @(posedge clk);
        #1 rst_n = 1;
        xact(2'd2, 7, 0, 9'd7, 0);
        repeat (3000) drive_rand();
        done = 1;
        iv = 0;
        ore = 1;
        repeat (10) @(posedge clk);
        fin = 1;
      end
    end else begin : r
      initial begin
        iv = 0; op = 0; a = 0; b = 0; ore = 1;
        while (!done) drive_rand();
        iv = 0;
        ore = 1;
      end
    end
  end
  initial begin
    wait (fin);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width in bits; legal range is 4..32.
REQ-002 Parameter LATENCY, default 2, SHALL set the number of register stages from acceptance to output; legal range is 1..4.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-low; reset=0 clears all state immediately.
REQ-005 in_valid  input  1  SHALL indicate that the operand/op fields are valid.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts a transaction this cycle.
REQ-007 op  input  2  SHALL select the operation: 00 add, 01 subtract, 10 accumulate, 11 clear-accumulator.
REQ-008 A  input  WIDTH  SHALL carry the first operand.
REQ-009 B  input  WIDTH  SHALL carry the second operand, which is ignored for op 10 and 11.
REQ-010 out_valid  output  1  SHALL indicate that sum/ovf hold a result.
REQ-011 out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-012 sum  output  WIDTH+1  SHALL carry the result.
REQ-013 ovf  output  1  SHALL carry the signed overflow flag of the result.

Function
REQ-014 A transaction SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; a result SHALL be consumed on a rising edge where out_valid=1 and out_ready=1.
REQ-015 The pipeline advance enable SHALL be (out_ready | ~out_valid), and in_ready SHALL equal advance; in_ready SHALL be combinational from out_ready and out_valid only, never from in_valid.
REQ-016 When advance=0, every stage SHALL hold its contents, and sum, ovf and out_valid SHALL be stable until consumed.
REQ-017 When advance=1, every stage SHALL shift by one; a stage with no accepted input SHALL become a bubble (valid=0). Bubbles are not compressed.
REQ-018 Latency: with advance=1 continuously, a transaction accepted at edge N SHALL present out_valid=1 after edge N+LATENCY-1; throughput SHALL be one transaction per cycle.
REQ-019 Add (op=00): sum SHALL be {0,A}+{0,B}; sum[WIDTH] is the carry.
REQ-020 Subtract (op=01): sum SHALL be ({0,A}-{0,B}) mod 2^(WIDTH+1); sum[WIDTH]=1 SHALL mean borrow (A<B unsigned).
REQ-021 For op 00 and 01, ovf SHALL be two's-complement overflow of the WIDTH-bit signed operation, taking A and B as signed.
REQ-022 Accumulator: an internal WIDTH+1-bit register acc SHALL be updated at the acceptance edge only, in acceptance order.
REQ-023 Accumulate (op=10): acc_next SHALL be (acc+{0,A}) mod 2^(WIDTH+1), and sum SHALL be acc_next.
REQ-024 For op=10, ovf SHALL be the carry out of bit WIDTH; the accumulator wraps.
REQ-025 Clear (op=11): acc SHALL become 0, and sum and ovf SHALL be 0.
REQ-026 Op 00 and 01 SHALL NOT modify acc.
REQ-027 No state SHALL change on an edge where in_valid=1 and in_ready=0; the producer holds its fields until accepted.
REQ-028 Accepting a new transaction and consuming a result on the same edge SHALL be legal and lossless.
REQ-029 out_valid SHALL be a registered output; sum and ovf SHALL be registered outputs of the last stage.

Reset
REQ-030 While reset=0: all stage valids, out_valid, sum, ovf and acc SHALL be 0.
REQ-031 While reset=0: in_ready SHALL be 1, because out_valid=0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight transactions, with no partial output after release.
REQ-033 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Verification (WIDTH=8, LATENCY=2 unless stated)
REQ-034 Add A=200, B=100, out_ready=1 held -> one cycle after acceptance, sum=300 (0x12C), ovf=0; A=100, B=100 -> sum=200, ovf=1.
REQ-035 Sub A=5, B=10 -> sum=0x1FB (borrow=1), ovf=0; A=0x80, B=0x01 -> sum=0x07F, ovf=1.
REQ-036 Clear, then accumulate A=255 twice, then A=3 -> sums 255, 510, 1 (wrap), with ovf=0, 0, 1.
REQ-037 Stream 8 back-to-back adds with out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 8 results in order, none lost or duplicated.
REQ-038 Assert reset with 2 transactions in flight -> out_valid=0 immediately, acc=0; after release, accumulate A=7 -> sum=7.
REQ-039 LATENCY=1 and LATENCY=4, WIDTH=16, random ops with random out_ready -> results match the reference model, and latency equals LATENCY cycles under no stall.
